// File: rtl/exec_unit.sv
// Multicycle execute/writeback stage in front of an 8x8 register file.
// Runs single-cycle ALU ops or an 8-iteration shift-add multiply, then writes back.
module exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [2:0]  read_addr1,
    output logic [2:0]  read_addr2,
    input  logic [7:0]  read_data1,
    input  logic [7:0]  read_data2,
    output logic        w_en,
    output logic [2:0]  write_addr,
    output logic [7:0]  write_data,
    output logic        done,
    output logic        illegal,
    output logic        flag_z,
    output logic        flag_c
);

    typedef enum logic [1:0] {IDLE, READ, MUL, WB} state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  result_q, result_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_c_q, flag_c_d;
    logic        in_ready_q, in_ready_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        w_en_q, w_en_d;

    logic [3:0]  op;
    logic [2:0]  rd;
    logic [8:0]  sum9;
    logic [7:0]  alu_res;
    logic        alu_c;
    logic [15:0] mul_acc;
    logic        enter_wb;
    logic        wb_c;
    logic        legal;

    assign op         = instr_q[15:12];
    assign rd         = instr_q[11:9];
    assign read_addr1 = instr_q[8:6];
    assign read_addr2 = instr_q[5:3];
    assign legal      = (op != 4'd0) && (op <= 4'd9);
    assign mul_acc    = acc_q + (mplier_q[0] ? mcand_q : 16'd0);

    always_comb begin
        sum9    = {1'b0, read_data1} + {1'b0, read_data2};
        alu_res = 8'd0;
        alu_c   = 1'b0;
        case (op)
            4'd1: begin
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
            end
            4'd2: begin
                alu_res = read_data1 - read_data2;
                alu_c   = read_data1 < read_data2;
            end
            4'd3:    alu_res = read_data1 & read_data2;
            4'd4:    alu_res = read_data1 | read_data2;
            4'd5:    alu_res = read_data1 ^ read_data2;
            4'd6:    alu_res = read_data1 << read_data2[2:0];
            4'd7:    alu_res = read_data1 >> read_data2[2:0];
            4'd8:    alu_res = instr_q[7:0];
            default: alu_res = 8'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        w_en_d    = 1'b0;
        enter_wb  = 1'b0;
        wb_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = READ;
                end
            end
            READ: begin
                mcand_d  = {8'd0, read_data1};
                mplier_d = read_data2;
                if (op == 4'd9) begin
                    acc_d   = 16'd0;
                    cnt_d   = 3'd0;
                    state_d = MUL;
                end else begin
                    result_d = alu_res;
                    wb_c     = alu_c;
                    enter_wb = 1'b1;
                    state_d  = WB;
                end
            end
            MUL: begin
                acc_d    = mul_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d = mul_acc[7:0];
                    wb_c     = |mul_acc[15:8];
                    enter_wb = 1'b1;
                    state_d  = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flags and strobes are loaded on entry to WB so they are visible during WB itself
        if (enter_wb) begin
            done_d    = 1'b1;
            illegal_d = op >= 4'd10;
            w_en_d    = legal && (rd != 3'd0);
            if (legal) begin
                flag_z_d = (result_d == 8'd0);
                flag_c_d = wb_c;
            end
        end

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= 16'd0;
            mcand_q    <= 16'd0;
            mplier_q   <= 8'd0;
            acc_q      <= 16'd0;
            cnt_q      <= 3'd0;
            result_q   <= 8'd0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            w_en_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            w_en_q     <= w_en_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign done       = done_q;
    assign illegal    = illegal_q;
    assign w_en       = w_en_q;
    assign write_addr = rd;
    assign write_data = result_q;
    assign flag_z     = flag_z_q;
    assign flag_c     = flag_c_q;

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: behavioural register file, directed scenarios and a
// randomized run checked against an arithmetic reference model.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [2:0]  read_addr1, read_addr2;
    logic [7:0]  read_data1, read_data2;
    logic        w_en;
    logic [2:0]  write_addr;
    logic [7:0]  write_data;
    logic        done, illegal, flag_z, flag_c;

    exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(read_data1), .read_data2(read_data2), .w_en(w_en),
        .write_addr(write_addr), .write_data(write_data), .done(done),
        .illegal(illegal), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    // Register file environment: r0 reads zero, a preset port loads values while idle
    logic [7:0] regs [8];
    logic       preset_en = 1'b0;
    logic [2:0] preset_addr = 3'd0;
    logic [7:0] preset_data = 8'd0;
    int         wen_seen = 0;

    assign read_data1 = (read_addr1 == 3'd0) ? 8'd0 : regs[read_addr1];
    assign read_data2 = (read_addr2 == 3'd0) ? 8'd0 : regs[read_addr2];

    always @(posedge clk) begin
        if (preset_en)
            regs[preset_addr] <= preset_data;
        else if (w_en && write_addr != 3'd0)
            regs[write_addr] <= write_data;
        if (w_en)
            wen_seen <= wen_seen + 1;
    end

    // Reference model state
    logic [7:0] exp_regs [8];
    logic       exp_z = 1'b0;
    logic       exp_c = 1'b0;
    logic [7:0] e_res;
    logic       e_c, e_legal, e_wr;

    typedef struct {
        int         cycles;
        logic       w_en;
        logic       illegal;
        logic       z;
        logic       c;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic       ready_after;
        logic       done_after;
    } obs_t;
    obs_t obs;

    int n_checks = 0;
    int n_fail = 0;

    function automatic int model_read(input logic [2:0] a);
        return (a == 3'd0) ? 0 : int'(exp_regs[a]);
    endfunction

    function automatic void ref_exec(input logic [15:0] ins, output logic [7:0] res,
                                     output logic c, output logic legal, output logic wr);
        int a, b, p, op;
        op = int'(ins[15:12]);
        a  = model_read(ins[8:6]);
        b  = model_read(ins[5:3]);
        p  = 0;
        c  = 1'b0;
        case (op)
            1: begin p = a + b; c = (p > 255); end
            2: begin p = a - b + 256; c = (a < b); end
            3: p = a & b;
            4: p = a | b;
            5: p = a ^ b;
            6: p = a * (2 ** (b % 8));
            7: p = a / (2 ** (b % 8));
            8: p = int'(ins[7:0]);
            9: begin p = a * b; c = (p > 255); end
            default: p = 0;
        endcase
        res   = 8'(p % 256);
        legal = (op >= 1) && (op <= 9);
        wr    = legal && (ins[11:9] != 3'd0);
    endfunction

    task automatic set_reg(input logic [2:0] a, input logic [7:0] d);
        preset_en   = 1'b1;
        preset_addr = a;
        preset_data = d;
        @(negedge clk);
        preset_en   = 1'b0;
        exp_regs[a] = d;
    endtask

    // Issues one instruction, captures what the DUT shows in WB and the cycle after, updates the model
    task automatic run_instr(input logic [15:0] ins);
        int guard;
        ref_exec(ins, e_res, e_c, e_legal, e_wr);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_instr = ins;
        obs.cycles = 0;
        do begin
            @(negedge clk);
            obs.cycles++;
            in_valid = 1'b0;
        end while (!done && obs.cycles < 30);
        obs.w_en    = w_en;
        obs.illegal = illegal;
        obs.z       = flag_z;
        obs.c       = flag_c;
        obs.waddr   = write_addr;
        obs.wdata   = write_data;
        @(negedge clk);
        obs.ready_after = in_ready;
        obs.done_after  = done;
        if (e_legal) begin
            exp_z = (e_res == 8'd0);
            exp_c = e_c;
        end
        if (e_wr)
            exp_regs[ins[11:9]] = e_res;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'd0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_checks++; if ({w_en, done, illegal} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_strobes: got %03b expected 000", {w_en, done, illegal}); end
        n_checks++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags: got %02b expected 00", {flag_z, flag_c}); end
        n_checks++; if ({read_addr1, read_addr2, write_addr, write_data} !== 17'd0) begin n_fail++; $display("[TB] FAIL reset_addr_data: got %0h expected 0", {read_addr1, read_addr2, write_addr, write_data}); end
        rst = 1'b0;
        exp_regs[0] = 8'd0;
        for (int i = 1; i < 8; i++) set_reg(3'(i), 8'($urandom));
    endtask

    task automatic test_add();
        set_reg(3'd1, 8'd200);
        set_reg(3'd2, 8'd100);
        run_instr({4'd1, 3'd3, 3'd1, 3'd2, 3'd0});
        n_checks++; if (obs.cycles !== 2) begin n_fail++; $display("[TB] FAIL add_latency: got %0d expected 2", obs.cycles); end
        n_checks++; if ({obs.w_en, obs.waddr} !== {1'b1, 3'd3}) begin n_fail++; $display("[TB] FAIL add_wen_addr: got %0b/%0d expected 1/3", obs.w_en, obs.waddr); end
        n_checks++; if (obs.wdata !== 8'd44) begin n_fail++; $display("[TB] FAIL add_data: got %0d expected 44", obs.wdata); end
        n_checks++; if ({obs.z, obs.c} !== 2'b01) begin n_fail++; $display("[TB] FAIL add_flags: got z=%0b c=%0b expected z=0 c=1", obs.z, obs.c); end
        n_checks++; if ({obs.ready_after, obs.done_after} !== 2'b10) begin n_fail++; $display("[TB] FAIL add_after_wb: got ready=%0b done=%0b expected 1/0", obs.ready_after, obs.done_after); end
        n_checks++; if (regs[3] !== 8'd44) begin n_fail++; $display("[TB] FAIL add_regfile: got %0d expected 44", regs[3]); end
    endtask

    task automatic test_sub();
        set_reg(3'd1, 8'd5);
        set_reg(3'd2, 8'd5);
        run_instr({4'd2, 3'd4, 3'd1, 3'd2, 3'd0});
        n_checks++; if (obs.wdata !== 8'd0) begin n_fail++; $display("[TB] FAIL sub_eq_data: got %0d expected 0", obs.wdata); end
        n_checks++; if ({obs.z, obs.c} !== 2'b10) begin n_fail++; $display("[TB] FAIL sub_eq_flags: got z=%0b c=%0b expected z=1 c=0", obs.z, obs.c); end
        set_reg(3'd1, 8'd3);
        run_instr({4'd2, 3'd4, 3'd1, 3'd2, 3'd0});
        n_checks++; if (obs.wdata !== 8'd254) begin n_fail++; $display("[TB] FAIL sub_borrow_data: got %0d expected 254", obs.wdata); end
        n_checks++; if ({obs.z, obs.c} !== 2'b01) begin n_fail++; $display("[TB] FAIL sub_borrow_flags: got z=%0b c=%0b expected z=0 c=1", obs.z, obs.c); end
    endtask

    task automatic test_mul();
        set_reg(3'd1, 8'd20);
        set_reg(3'd2, 8'd13);
        run_instr({4'd9, 3'd6, 3'd1, 3'd2, 3'd0});
        n_checks++; if (obs.cycles !== 10) begin n_fail++; $display("[TB] FAIL mul_latency: got %0d expected 10", obs.cycles); end
        n_checks++; if (obs.wdata !== 8'd4) begin n_fail++; $display("[TB] FAIL mul_data: got %0d expected 4", obs.wdata); end
        n_checks++; if ({obs.z, obs.c} !== 2'b01) begin n_fail++; $display("[TB] FAIL mul_flags: got z=%0b c=%0b expected z=0 c=1", obs.z, obs.c); end
        set_reg(3'd1, 8'd15);
        set_reg(3'd2, 8'd17);
        run_instr({4'd9, 3'd6, 3'd1, 3'd2, 3'd0});
        n_checks++; if (obs.wdata !== 8'd255) begin n_fail++; $display("[TB] FAIL mul2_data: got %0d expected 255", obs.wdata); end
        n_checks++; if ({obs.z, obs.c} !== 2'b00) begin n_fail++; $display("[TB] FAIL mul2_flags: got z=%0b c=%0b expected z=0 c=0", obs.z, obs.c); end
        n_checks++; if (regs[6] !== 8'd255) begin n_fail++; $display("[TB] FAIL mul2_regfile: got %0d expected 255", regs[6]); end
    endtask

    task automatic test_li_illegal();
        set_reg(3'd1, 8'd5);
        set_reg(3'd2, 8'd5);
        run_instr({4'd2, 3'd4, 3'd1, 3'd2, 3'd0});
        run_instr({4'd8, 3'd0, 1'b0, 8'hA5});
        n_checks++; if ({obs.w_en, obs.cycles == 2} !== 2'b01) begin n_fail++; $display("[TB] FAIL li_r0_wen: got wen=%0b cycles=%0d expected 0/2", obs.w_en, obs.cycles); end
        n_checks++; if (obs.wdata !== 8'hA5) begin n_fail++; $display("[TB] FAIL li_r0_data: got %0h expected a5", obs.wdata); end
        n_checks++; if ({obs.z, obs.c} !== 2'b00) begin n_fail++; $display("[TB] FAIL li_r0_flags: got z=%0b c=%0b expected z=0 c=0", obs.z, obs.c); end
        set_reg(3'd1, 8'd3);
        run_instr({4'd2, 3'd4, 3'd1, 3'd2, 3'd0});
        run_instr({4'd12, 12'hFFF});
        n_checks++; if ({obs.illegal, obs.w_en} !== 2'b10) begin n_fail++; $display("[TB] FAIL illegal_strobes: got illegal=%0b wen=%0b expected 1/0", obs.illegal, obs.w_en); end
        n_checks++; if (obs.cycles !== 2) begin n_fail++; $display("[TB] FAIL illegal_latency: got %0d expected 2", obs.cycles); end
        n_checks++; if ({obs.z, obs.c} !== 2'b01) begin n_fail++; $display("[TB] FAIL illegal_flags_kept: got z=%0b c=%0b expected z=0 c=1", obs.z, obs.c); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int wen_before;
        set_reg(3'd1, 8'h3C);
        set_reg(3'd2, 8'h0F);
        set_reg(3'd4, 8'h11);
        in_valid = 1'b1;
        in_instr = {4'd1, 3'd7, 3'd1, 3'd2, 3'd0};
        @(negedge clk);
        in_instr = {4'd5, 3'd5, 3'd1, 3'd2, 3'd0};
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy_read: got %0b expected 0", in_ready); end
        @(negedge clk);
        n_checks++; if ({done, write_addr, write_data} !== {1'b1, 3'd7, 8'h4B}) begin n_fail++; $display("[TB] FAIL b2b_first_wb: got %0h expected %0h", {done, write_addr, write_data}, {1'b1, 3'd7, 8'h4B}); end
        @(negedge clk);
        n_checks++; if ({in_ready, done} !== 2'b10) begin n_fail++; $display("[TB] FAIL b2b_idle_gap: got ready=%0b done=%0b expected 1/0", in_ready, done); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_second_accept: got %0b expected 0", in_ready); end
        @(negedge clk);
        n_checks++; if ({done, write_addr, write_data} !== {1'b1, 3'd5, 8'h33}) begin n_fail++; $display("[TB] FAIL b2b_second_wb: got %0h expected %0h", {done, write_addr, write_data}, {1'b1, 3'd5, 8'h33}); end
        @(negedge clk);
        exp_regs[7] = 8'h4B;
        exp_regs[5] = 8'h33;
        wen_before = wen_seen;
        in_valid = 1'b1;
        in_instr = {4'd9, 3'd2, 3'd1, 3'd2, 3'd0};
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!done) begin
                in_valid = cyc[0];
                in_instr = {4'd8, 3'd4, 1'b0, 8'h77};
            end
        end while (!done && cyc < 30);
        in_valid = 1'b0;
        n_checks++; if (cyc !== 10) begin n_fail++; $display("[TB] FAIL b2b_mul_latency: got %0d expected 10", cyc); end
        n_checks++; if (write_data !== 8'd132) begin n_fail++; $display("[TB] FAIL b2b_mul_data: got %0d expected 132", write_data); end
        repeat (4) @(negedge clk);
        n_checks++; if (wen_seen - wen_before !== 1) begin n_fail++; $display("[TB] FAIL b2b_pulses_ignored_wen: got %0d writes expected 1", wen_seen - wen_before); end
        n_checks++; if (regs[4] !== 8'h11) begin n_fail++; $display("[TB] FAIL b2b_pulses_ignored_reg: got %0h expected 11", regs[4]); end
        exp_regs[2] = 8'd132;
        exp_z = 1'b0;
        exp_c = 1'b1;
    endtask

    task automatic test_mul_reset();
        int wen_before;
        set_reg(3'd1, 8'd3);
        set_reg(3'd2, 8'd5);
        set_reg(3'd5, 8'h5A);
        run_instr({4'd2, 3'd4, 3'd1, 3'd2, 3'd0});
        wen_before = wen_seen;
        in_valid = 1'b1;
        in_instr = {4'd9, 3'd5, 3'd1, 3'd2, 3'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({in_ready, done, w_en} !== 3'b100) begin n_fail++; $display("[TB] FAIL mulrst_state: got %03b expected 100", {in_ready, done, w_en}); end
        n_checks++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("[TB] FAIL mulrst_flags: got %02b expected 00", {flag_z, flag_c}); end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++; if (wen_seen !== wen_before) begin n_fail++; $display("[TB] FAIL mulrst_no_write: got %0d writes expected 0", wen_seen - wen_before); end
        n_checks++; if (regs[5] !== 8'h5A) begin n_fail++; $display("[TB] FAIL mulrst_reg_kept: got %0h expected 5a", regs[5]); end
        exp_z = 1'b0;
        exp_c = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                set_reg(3'($urandom_range(1, 7)), 8'($urandom));
            ins = 16'($urandom);
            run_instr(ins);
            n_checks++; if (obs.cycles !== ((ins[15:12] == 4'd9) ? 10 : 2)) begin n_fail++; $display("[TB] FAIL rnd_latency %04h: got %0d", ins, obs.cycles); end
            n_checks++; if ({obs.w_en, obs.illegal, obs.waddr} !== {e_wr, ins[15:12] >= 4'd10, ins[11:9]}) begin n_fail++; $display("[TB] FAIL rnd_strobes %04h: got %0b%0b/%0d expected %0b%0b/%0d", ins, obs.w_en, obs.illegal, obs.waddr, e_wr, ins[15:12] >= 4'd10, ins[11:9]); end
            if (e_legal) begin
                n_checks++; if (obs.wdata !== e_res) begin n_fail++; $display("[TB] FAIL rnd_data %04h: got %0d expected %0d", ins, obs.wdata, e_res); end
            end
            n_checks++; if ({obs.z, obs.c} !== {exp_z, exp_c}) begin n_fail++; $display("[TB] FAIL rnd_flags %04h: got %0b%0b expected %0b%0b", ins, obs.z, obs.c, exp_z, exp_c); end
            n_checks++; if (regs[ins[11:9]] !== exp_regs[ins[11:9]] && ins[11:9] != 3'd0) begin n_fail++; $display("[TB] FAIL rnd_regfile %04h: got %0d expected %0d", ins, regs[ins[11:9]], exp_regs[ins[11:9]]); end
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_li_illegal();
        test_back_to_back();
        test_mul_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
